// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types for the boot ROM arbiter: response ownership, grant vector,
// starvation counter width and the common word type.
package rom_bus_arbiter_pkg;

    localparam int STARVE_CNT_W = 4;
    localparam int WORD_W       = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } rom_owner_t;

    typedef struct packed {
        logic inst;
        logic data;
    } grant_t;

    function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational grant selection: inst wins ties unless the data master has
// been losing for STARVE_LIMIT or more consecutive eligible cycles.
module rom_arb_pick
    import rom_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    inst_elig,
    input  logic                    data_elig,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output grant_t                  grant
);

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        if (inst_elig && data_elig) begin
            if (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT)) begin
                grant.data = 1'b1;
            end else begin
                grant.inst = 1'b1;
            end
        end else begin
            grant.inst = inst_elig;
            grant.data = data_elig;
        end
    end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one dual-word, 1-cycle-latency boot ROM port between the instruction
// fetch and data load masters; returned words are steered by the owner register.
module rom_bus_arbiter
    import rom_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_stall,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic [DATA_WIDTH-1:0] inst_rdata_2,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_stall,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic [DATA_WIDTH-1:0] rom_rdata_2
);

    rom_owner_t              owner_q, owner_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    inst_elig, data_elig;
    grant_t                  grant;

    // A master is not eligible in its own response cycle, and nothing is granted while rst is high.
    always_comb begin
        inst_elig = inst_req & (owner_q != OWN_INST) & ~rst;
        data_elig = data_req & (owner_q != OWN_DATA) & ~rst;
    end

    rom_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .inst_elig (inst_elig),
        .data_elig (data_elig),
        .starve_cnt(starve_cnt_q),
        .grant     (grant)
    );

    always_comb begin
        rom_en       = grant.inst | grant.data;
        rom_addr     = '0;
        owner_d      = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        if (grant.inst) begin
            rom_addr = inst_addr;
            owner_d  = OWN_INST;
        end else if (grant.data) begin
            rom_addr = data_addr;
            owner_d  = OWN_DATA;
        end

        if (grant.data || !data_req) begin
            starve_cnt_d = '0;
        end else if (data_elig) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
        end
    end

    always_comb begin
        inst_valid   = (owner_q == OWN_INST);
        data_valid   = (owner_q == OWN_DATA);
        inst_rdata   = inst_valid ? rom_rdata   : '0;
        inst_rdata_2 = inst_valid ? rom_rdata_2 : '0;
        data_rdata   = data_valid ? rom_rdata   : '0;
        inst_stall   = inst_req & ~inst_valid & ~rst;
        data_stall   = data_req & ~data_valid & ~rst;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed self-checking bench for rom_bus_arbiter with a behavioural ROM.
module tb_rom_bus_arbiter;
    import rom_bus_arbiter_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  inst_req, data_req;
    word_t inst_addr, data_addr;
    logic  inst_stall, inst_valid, data_stall, data_valid, rom_en;
    word_t inst_rdata, inst_rdata_2, data_rdata, rom_addr;
    word_t rom_rdata = '0;
    word_t rom_rdata_2 = '0;

    int tests  = 0;
    int failed = 0;

    rom_bus_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_stall  (inst_stall),
        .inst_valid  (inst_valid),
        .inst_rdata  (inst_rdata),
        .inst_rdata_2(inst_rdata_2),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_stall  (data_stall),
        .data_valid  (data_valid),
        .data_rdata  (data_rdata),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .rom_rdata_2 (rom_rdata_2)
    );

    always #5 clk = ~clk;

    // ROM contents: two fixed words at 0x10/0x14, otherwise address ^ 0xC0DE0000.
    function automatic word_t rom_word(input word_t a);
        if (a == 32'h10) return 32'h1111_1111;
        if (a == 32'h14) return 32'h2222_2222;
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) begin
        if (rom_en) begin
            rom_rdata   <= rom_word(rom_addr);
            rom_rdata_2 <= rom_word(rom_addr + 32'd4);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rom_en"},     rom_en,       0);
        check({tag, ".rom_addr"},   rom_addr,     0);
        check({tag, ".inst_stall"}, inst_stall,   0);
        check({tag, ".data_stall"}, data_stall,   0);
        check({tag, ".inst_valid"}, inst_valid,   0);
        check({tag, ".data_valid"}, data_valid,   0);
        check({tag, ".inst_rdata"}, inst_rdata,   0);
        check({tag, ".inst_rd2"},   inst_rdata_2, 0);
        check({tag, ".data_rdata"}, data_rdata,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        inst_req  = 1'b0;
        data_req  = 1'b0;
        inst_addr = '0;
        data_addr = '0;
        repeat (2) tick();

        // Reset holds every output low even with both requests raised.
        inst_req = 1'b1; data_req = 1'b1;
        inst_addr = 32'h100; data_addr = 32'h200;
        settle();
        check_all_zero("reset");
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Idle.
        tick(); settle();
        check_all_zero("idle");

        // Single inst request.
        tick();
        inst_req = 1'b1; inst_addr = 32'h10;
        settle();
        check("t1.c0.rom_en",     rom_en,     1);
        check("t1.c0.rom_addr",   rom_addr,   32'h10);
        check("t1.c0.inst_stall", inst_stall, 1);
        check("t1.c0.inst_valid", inst_valid, 0);
        tick(); settle();
        check("t1.c1.inst_valid", inst_valid,   1);
        check("t1.c1.inst_rdata", inst_rdata,   32'h1111_1111);
        check("t1.c1.inst_rd2",   inst_rdata_2, 32'h2222_2222);
        check("t1.c1.inst_stall", inst_stall,   0);
        check("t1.c1.rom_en",     rom_en,       0);
        inst_req = 1'b0;
        tick(); settle();
        check("t1.c2.inst_valid", inst_valid, 0);

        // Both masters: strict alternation, starvation counter observed.
        tick();
        inst_req = 1'b1; data_req = 1'b1;
        inst_addr = 32'h100; data_addr = 32'h200;
        settle();
        check("t2.c0.rom_en",     rom_en,     1);
        check("t2.c0.rom_addr",   rom_addr,   32'h100);
        check("t2.c0.inst_stall", inst_stall, 1);
        check("t2.c0.data_stall", data_stall, 1);
        tick(); settle();
        check("t2.c1.inst_valid", inst_valid,   1);
        check("t2.c1.inst_rdata", inst_rdata,   32'hC0DE_0100);
        check("t2.c1.inst_rd2",   inst_rdata_2, 32'hC0DE_0104);
        check("t2.c1.data_rdata", data_rdata,   0);
        check("t2.c1.rom_en",     rom_en,       1);
        check("t2.c1.rom_addr",   rom_addr,     32'h200);
        check("t2.c1.inst_stall", inst_stall,   0);
        check("t2.c1.data_stall", data_stall,   1);
        check("t3.c1.starve",     dut.starve_cnt_q, 1);
        tick(); settle();
        check("t2.c2.data_valid", data_valid,   1);
        check("t2.c2.data_rdata", data_rdata,   32'hC0DE_0200);
        check("t2.c2.inst_rdata", inst_rdata,   0);
        check("t2.c2.inst_rd2",   inst_rdata_2, 0);
        check("t2.c2.rom_en",     rom_en,       1);
        check("t2.c2.rom_addr",   rom_addr,     32'h100);
        check("t2.c2.data_stall", data_stall,   0);
        check("t2.c2.inst_stall", inst_stall,   1);
        check("t3.c2.starve",     dut.starve_cnt_q, 0);
        tick(); settle();
        check("t2.c3.inst_valid", inst_valid, 1);
        check("t2.c3.rom_addr",   rom_addr,   32'h200);
        check("t2.c3.rom_en",     rom_en,     1);
        tick(); settle();
        check("t2.c4.data_valid", data_valid, 1);
        check("t2.c4.data_rdata", data_rdata, 32'hC0DE_0200);
        check("t2.c4.rom_addr",   rom_addr,   32'h100);
        data_req = 1'b0;
        tick(); settle();
        check("t2.c5.inst_valid", inst_valid, 1);
        check("t2.c5.data_valid", data_valid, 0);
        check("t2.c5.rom_en",     rom_en,     0);
        inst_req = 1'b0;

        // Single data master back-to-back with advancing address.
        tick();
        data_req = 1'b1; data_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t4.g%0d.rom_en", i),   rom_en,   1);
            check($sformatf("t4.g%0d.rom_addr", i), rom_addr, 32'h300 + 32'(4 * i));
            tick(); settle();
            check($sformatf("t4.r%0d.rom_en", i),     rom_en,     0);
            check($sformatf("t4.r%0d.data_valid", i), data_valid, 1);
            check($sformatf("t4.r%0d.data_rdata", i), data_rdata, 32'hC0DE_0300 + 32'(4 * i));
            data_addr = data_addr + 32'd4;
            tick();
        end
        data_req = 1'b0;
        settle();
        check("t4.end.rom_en", rom_en, 0);

        // Asynchronous reset in the response cycle of an inst grant.
        tick();
        inst_req = 1'b1; inst_addr = 32'h40;
        settle();
        check("t5.c0.rom_en", rom_en, 1);
        tick();
        #1 rst = 1'b1;
        #1;
        check_all_zero("t5.rst");
        #1 rst = 1'b0;
        #1;
        check("t5.rel.rom_en",   rom_en,   1);
        check("t5.rel.rom_addr", rom_addr, 32'h40);
        tick(); settle();
        check("t5.c1.inst_valid", inst_valid,   1);
        check("t5.c1.inst_rdata", inst_rdata,   32'hC0DE_0040);
        check("t5.c1.inst_rd2",   inst_rdata_2, 32'hC0DE_0044);
        inst_req = 1'b0;
        tick(); settle();
        check_all_zero("t6.idle");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
